// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-FSM state encoding, data/counter widths and
// the 2-of-3 vote used by the receiver's optional majority sampler.
package uart_pkg;

   localparam int UART_DATA_W = 8;
   localparam int UART_CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line conditioning for uart_rx: 2-flop synchroniser, falling-edge detect and,
// with UART_RX_MAJORITY_EN defined, a 3-tap majority filter on the sample value.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s,
   output logic fall,
   output logic bit_val
);
   import uart_pkg::*;

   logic rx_meta;
   logic rx_prev;
`ifdef UART_RX_MAJORITY_EN
   logic rx_prev2;
`endif

   // Everything resets to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
         rx_prev2 <= 1'b1;
`endif
      end else begin
         rx_meta  <= rx;
         rx_s     <= rx_meta;
         rx_prev  <= rx_s;
`ifdef UART_RX_MAJORITY_EN
         rx_prev2 <= rx_prev;
`endif
      end
   end

   assign fall = rx_prev & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
   assign bit_val = maj3(rx_s, rx_prev, rx_prev2);
`else
   assign bit_val = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, odd parity, one stop bit; writes bytes
// into the RX FIFO. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CNT_W = UART_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx_en,
   input  logic                   rx,
   input  logic [31:0]            baud,
   input  logic                   full_i,
   output logic                   we_o,
   output logic [UART_DATA_W-1:0] data_o,
   output logic                   parity_err_o,
   output logic                   frame_err_o,
   output logic                   overflow_o,
   output logic                   busy_o
);

   uart_state_e            state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [CNT_W-1:0]       half, period;
   logic [2:0]             bitn, bitn_nxt;
   logic [UART_DATA_W-1:0] shift, shift_nxt, data_nxt;
   logic                   par, par_nxt;
   logic                   we_nxt, perr_nxt, ferr_nxt, ovf_nxt;
   logic                   fall, bit_val, rx_s_unused;
   logic                   half_tick, bit_tick;

   generate
      if (CNT_W < 32) begin : g_baud_hi
         logic baud_hi_unused;
         assign baud_hi_unused = ^baud[31:CNT_W];
      end
   endgenerate

   uart_rx_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx      (rx),
      .rx_s    (rx_s_unused),
      .fall    (fall),
      .bit_val (bit_val)
   );

   // Even bit period keeps the receiver on the transmitter's divided clock.
   assign half      = baud[CNT_W-1:0] >> 1;
   assign period    = {half[CNT_W-2:0], 1'b0};
   assign half_tick = (cnt == half - CNT_W'(1));
   assign bit_tick  = (cnt == period - CNT_W'(1));
   assign busy_o    = (state != IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      bitn_nxt  = bitn;
      shift_nxt = shift;
      par_nxt   = par;
      data_nxt  = data_o;
      we_nxt    = 1'b0;
      perr_nxt  = 1'b0;
      ferr_nxt  = 1'b0;
      ovf_nxt   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (fall && rx_en) state_nxt = START;
         end
         START: begin
            if (half_tick) begin
               cnt_nxt  = '0;
               bitn_nxt = '0;
               state_nxt = bit_val ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               cnt_nxt   = '0;
               shift_nxt = {bit_val, shift[UART_DATA_W-1:1]};
               bitn_nxt  = bitn + 3'd1;
               if (bitn == 3'd7) state_nxt = PARITY;
            end
         end
         PARITY: begin
            if (bit_tick) begin
               cnt_nxt   = '0;
               par_nxt   = bit_val;
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               if (!bit_val) begin
                  ferr_nxt = 1'b1;
               end else if (full_i) begin
                  ovf_nxt = 1'b1;
               end else begin
                  we_nxt   = 1'b1;
                  data_nxt = shift;
                  perr_nxt = ~(^{shift, par});
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         bitn         <= '0;
         shift        <= '0;
         par          <= 1'b0;
         data_o       <= '0;
         we_o         <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
         overflow_o   <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         bitn         <= bitn_nxt;
         shift        <= shift_nxt;
         par          <= par_nxt;
         data_o       <= data_nxt;
         we_o         <= we_nxt;
         parity_err_o <= perr_nxt;
         frame_err_o  <= ferr_nxt;
         overflow_o   <= ovf_nxt;
      end
   end

endmodule
